accel_spi_reader: RTL

- SPI master that burst-reads X/Y/Z acceleration from a 3-axis accelerometer (ADXL345-style register map, 10-bit two's-complement, right-justified).
- Converts each axis to the 10-bit sign-magnitude format the complementary-filter path consumes: bit 9 is the sign, bits 8:0 are the magnitude.
- Sits between the board SPI pins and the orientation filter's x/y/z_accel_data inputs. It is the producer side of that accel data interface.

---
 rtl/accel_spi_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/accel_spi_reader.sv
// SPI mode-3 master that burst-reads X/Y/Z from an ADXL345-style accelerometer
// and presents each axis as 10-bit sign-magnitude for the orientation filter.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [5:0]  BASE_ADDR = 6'h32
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic [9:0] x_accel_data,
  output logic [9:0] y_accel_data,
  output logic [9:0] z_accel_data,
  output logic       data_valid,
  output logic       busy
);

  localparam logic [7:0] CMD       = {2'b11, BASE_ADDR};
  localparam logic [9:0] DIV_LAST  = 10'(CLK_DIV - 1);
  localparam logic [6:0] LAST_EDGE = 7'd112;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state;
  logic [9:0]  div_cnt;
  logic [6:0]  edge_cnt;
  logic [6:0]  tx_shift;
  logic [47:0] rx_shift;

  // The most negative reading has no positive counterpart, so it clamps to full scale.
  function automatic logic [9:0] to_sign_mag(input logic [9:0] v);
    logic [8:0] mag;
    mag = ~v[8:0] + 9'd1;
    if (!v[9])
      return {1'b0, v[8:0]};
    else if (v == 10'h200)
      return 10'h3FF;
    else
      return {1'b1, mag};
  endfunction

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= IDLE;
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      data_valid   <= 1'b0;
      x_accel_data <= '0;
      y_accel_data <= '0;
      z_accel_data <= '0;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= DIV_LAST;
            edge_cnt <= '0;
            tx_shift <= CMD[6:0];
            mosi     <= CMD[7];
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            state    <= SHIFT;
            sclk     <= 1'b0;
            div_cnt  <= DIV_LAST;
            edge_cnt <= 7'd1;
          end else begin
            div_cnt <= div_cnt - 10'd1;
          end
        end
        SHIFT: begin
          // edge_cnt counts both sclk transitions; the last high half-period still runs out.
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 10'd1;
          end else if (edge_cnt == LAST_EDGE) begin
            state   <= HOLD;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt  <= DIV_LAST;
            edge_cnt <= edge_cnt + 7'd1;
            sclk     <= ~sclk;
            if (sclk) begin
              tx_shift <= {tx_shift[5:0], 1'b0};
              mosi     <= tx_shift[6];
            end else begin
              rx_shift <= {rx_shift[46:0], miso};
            end
          end
        end
        HOLD: begin
          if (div_cnt == '0) begin
            state        <= GAP;
            cs_n         <= 1'b1;
            mosi         <= 1'b0;
            data_valid   <= 1'b1;
            div_cnt      <= DIV_LAST;
            x_accel_data <= to_sign_mag({rx_shift[33:32], rx_shift[47:40]});
            y_accel_data <= to_sign_mag({rx_shift[17:16], rx_shift[31:24]});
            z_accel_data <= to_sign_mag({rx_shift[1:0],   rx_shift[15:8]});
          end else begin
            div_cnt <= div_cnt - 10'd1;
          end
        end
        GAP: begin
          if (div_cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            edge_cnt <= '0;
          end else begin
            div_cnt <= div_cnt - 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
